// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the DataMemory port between the CPU memory stage and a debug requester
module dmem_port_arbiter #(
    parameter int         DBITS        = 32,
    parameter int         STARVE_LIMIT = 4,
    parameter int         DBG_BURST    = 8,
    parameter logic [3:0] IO_MASK_HI   = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [DBITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    output logic [DBITS-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [DBITS-1:0] dbg_addr,
    input  logic [DBITS-1:0] dbg_wdata,
    output logic             dbg_gnt,
    output logic [DBITS-1:0] dbg_rdata,
    output logic             dbg_rvalid,
    output logic             dbg_err,
    output logic             mem_wrtEn,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_dIn,
    input  logic [DBITS-1:0] mem_dOut
);

    typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(DBG_BURST + 1);

    state_t          state, state_next;
    logic [SW-1:0]   starve_cnt, starve_next;
    logic [BW-1:0]   burst_cnt, burst_next;
    logic            conflict;
    logic            cpu_won;
    logic            dbg_won;
    logic            blocked;

    assign conflict  = cpu_req & dbg_req;
    assign cpu_rdata = mem_dOut;

    // State, counters and registered debug response
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_err    <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            burst_cnt  <= burst_next;
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            dbg_err    <= dbg_gnt & blocked;
            if (dbg_gnt && !dbg_we)
                dbg_rdata <= mem_dOut;
        end
    end

    // Starvation promotion into debug burst mode and bounded burst exit
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        burst_next  = burst_cnt;
        case (state)
            S_CPU: begin
                burst_next = '0;
                if (!conflict) begin
                    starve_next = '0;
                end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                    state_next  = S_DBG;
                    starve_next = '0;
                end else begin
                    starve_next = starve_cnt + 1'b1;
                end
            end
            S_DBG: begin
                starve_next = '0;
                if (!dbg_req) begin
                    state_next = S_CPU;
                    burst_next = '0;
                end else if (dbg_gnt) begin
                    if (burst_cnt == BW'(DBG_BURST - 1)) begin
                        state_next = S_CPU;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next  = S_CPU;
                starve_next = '0;
                burst_next  = '0;
            end
        endcase
    end

    // Grant decode and memory port steering; handshakes forced quiet during reset
    always_comb begin
        if (state == S_DBG) begin
            dbg_won = dbg_req;
            cpu_won = cpu_req & ~dbg_req;
        end else begin
            cpu_won = cpu_req;
            dbg_won = dbg_req & ~cpu_req;
        end
        blocked   = dbg_won & dbg_we & (dbg_addr[DBITS-1 -: 4] == IO_MASK_HI);
        mem_addr  = dbg_won ? dbg_addr  : cpu_addr;
        mem_dIn   = dbg_won ? dbg_wdata : cpu_wdata;
        mem_wrtEn = cpu_won ? cpu_we : (dbg_won & dbg_we & ~blocked);
        cpu_stall = cpu_req & ~cpu_won;
        dbg_gnt   = dbg_req & dbg_won;
        if (reset) begin
            mem_wrtEn = 1'b0;
            cpu_stall = 1'b0;
            dbg_gnt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int DBG_BURST    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid, dbg_err;
    logic        mem_wrtEn;
    logic [31:0] mem_addr, mem_dIn;
    logic [31:0] mem_dOut = '0;

    dmem_port_arbiter #(
        .DBITS(32), .STARVE_LIMIT(STARVE_LIMIT), .DBG_BURST(DBG_BURST), .IO_MASK_HI(4'hF)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err),
        .mem_wrtEn(mem_wrtEn), .mem_addr(mem_addr), .mem_dIn(mem_dIn), .mem_dOut(mem_dOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall, gnt, we, rvalid, err;
        logic [31:0] addr, din, rdata, dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: arbitration mode, conflict streak, grants taken in the current burst
    bit          m_dbg_mode = 0;
    int          m_streak = 0;
    int          m_burst = 0;
    logic        m_rvalid = 0, m_err = 0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents its port, pop the expectation and compare
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
            chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e.gnt});
            chk("mem_wrtEn", {31'd0, mem_wrtEn}, {31'd0, e.we});
            chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e.rvalid});
            chk("dbg_err", {31'd0, dbg_err}, {31'd0, e.err});
            chk("dbg_rdata", dbg_rdata, e.rdata);
            chk("cpu_rdata", cpu_rdata, e.dout);
            if (!e.rst) begin
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_dIn", mem_dIn, e.din);
            end
        end
    end

    task automatic step(input logic rst, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] dout, output logic g);
        exp_t e;
        bit   cpu_wins, dbg_wins, blk;
        @(posedge clk);
        #1;
        reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; mem_dOut = dout;
        e.rst = rst; e.rvalid = m_rvalid; e.err = m_err; e.rdata = m_rdata; e.dout = dout;
        // Default owner takes the port; the other side gets it only when the owner is idle
        cpu_wins = cr && (!m_dbg_mode || !dr);
        dbg_wins = dr && !cpu_wins;
        blk      = dbg_wins && dw && (da[31:28] == 4'hF);
        e.addr  = dbg_wins ? da : ca;
        e.din   = dbg_wins ? dd : cd;
        e.we    = !rst && (cpu_wins ? cw : (dbg_wins && dw && !blk));
        e.stall = !rst && cr && !cpu_wins;
        e.gnt   = !rst && dbg_wins;
        exp_q.push_back(e);
        if (rst) begin
            m_dbg_mode = 0; m_streak = 0; m_burst = 0;
            m_rvalid = 0; m_err = 0; m_rdata = '0;
        end else begin
            m_rvalid = e.gnt && !dw;
            m_err    = e.gnt && blk;
            if (e.gnt && !dw) m_rdata = dout;
            if (!m_dbg_mode) begin
                if (cr && dr) begin
                    m_streak++;
                    if (m_streak == STARVE_LIMIT) begin
                        m_dbg_mode = 1; m_streak = 0; m_burst = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end else if (!dr) begin
                m_dbg_mode = 0; m_burst = 0;
            end else begin
                m_burst++;
                if (m_burst == DBG_BURST) begin
                    m_dbg_mode = 0; m_burst = 0;
                end
            end
        end
        g = e.gnt;
    endtask

    initial begin
        logic        g;
        logic        pend, pw, cr, cw;
        logic [31:0] pa, pd;
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, g);
        step(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2, 32'h5, g);
        // T1: uncontested CPU write
        step(0, 1, 1, 32'h100, 32'hA5, 0, 0, 0, 0, 32'h0, g);
        // T2: debug read alone, data one cycle later
        step(0, 0, 0, 32'h0, 0, 1, 0, 32'h40, 0, 32'h1234, g);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, g);
        // T3: continuous conflict, two full starve/burst periods
        for (int i = 0; i < 28; i++)
            step(0, 1, 0, 32'h200 + i, 0, 1, 0, 32'h300 + i, 0, $urandom, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, g);
        // T4: enter burst mode, drop debug request after two grants
        for (int i = 0; i < STARVE_LIMIT + 2; i++)
            step(0, 1, 1, 32'h400, 32'h11, 1, 1, 32'h500 + i, 32'h22, $urandom, g);
        step(0, 1, 1, 32'h404, 32'h33, 0, 0, 0, 0, 32'h0, g);
        step(0, 1, 0, 32'h408, 32'h0, 1, 0, 32'h600, 0, 32'h7, g);
        // T5: blocked debug MMIO write, then CPU MMIO write goes through
        step(0, 0, 0, 0, 0, 1, 1, 32'hF0000004, 32'hFF, 32'h0, g);
        step(0, 1, 1, 32'hF0000004, 32'h3, 0, 0, 0, 0, 32'h0, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, g);
        // T6: reset right after a granted debug read, mid-burst
        for (int i = 0; i < STARVE_LIMIT + 1; i++)
            step(0, 1, 0, 32'h700, 0, 1, 0, 32'h800, 0, $urandom, g);
        step(1, 1, 0, 32'h700, 0, 1, 0, 32'h800, 0, 32'hDEAD, g);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'h704, 0, 1, 0, 32'h804, 0, $urandom, g);
        // Random traffic: debug holds its request until granted
        pend = 0; pw = 0; pa = '0; pd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend && ($urandom_range(0, 2) != 0)) begin
                pend = 1;
                pw   = 1'($urandom_range(0, 1));
                pa   = $urandom;
                pa[31:28] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                pd   = $urandom;
            end
            cr = ($urandom_range(0, 9) < 7);
            cw = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 199) == 0), cr, cw, $urandom, $urandom,
                 pend, pw, pa, pd, $urandom, g);
            if (g) pend = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, g);
        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
